// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: rebuilds hcount/vcount from incoming syncs,
// measures line/frame periods and sync widths, and tracks lock with a 4-state FSM.
module vga_sync_decoder #(
  parameter int H_TOTAL      = 1056,
  parameter int V_TOTAL      = 628,
  parameter int H_SYNC_FIRST = 840,
  parameter int H_SYNC_LEN   = 128,
  parameter int V_SYNC_FIRST = 601,
  parameter int V_SYNC_LEN   = 4,
  parameter int LOCK_LINES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {SEARCH = 2'd0, H_ACQ = 2'd1, V_ACQ = 2'd2, LOCKED = 2'd3} state_t;

  localparam logic [11:0] WD_LIMIT = 12'(2 * H_TOTAL - 1);

  state_t      state, state_nx;
  logic        hs_q, vs_q, hb_q, vb_q, hs_q_d, vs_q_d;
  logic [11:0] line_cnt, hs_run;
  logic [10:0] frame_lines, vs_run;
  logic [7:0]  good_cnt, good_nx;
  logic        v_armed, armed_nx;
  logic        h_err_nx, v_err_nx, wd_trip;
  logic        hs_rise, hs_fall, vs_rise, vs_fall, h_wrap;

  assign hs_rise   = hs_q & ~hs_q_d;
  assign hs_fall   = ~hs_q & hs_q_d;
  assign vs_rise   = vs_q & ~vs_q_d;
  assign vs_fall   = ~vs_q & vs_q_d;
  assign h_wrap    = (hcount == 11'(H_TOTAL - 1));
  assign state_dbg = state;

  // Stage 1: input capture plus the previous-sample copies used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0; vs_q <= 1'b0; hb_q <= 1'b0; vb_q <= 1'b0;
      hs_q_d <= 1'b0; vs_q_d <= 1'b0;
    end else begin
      hs_q <= hsync_in; vs_q <= vsync_in; hb_q <= hblnk_in; vb_q <= vblnk_in;
      hs_q_d <= hs_q; vs_q_d <= vs_q;
    end
  end

  always_comb begin
    h_err_nx = 1'b0;
    v_err_nx = 1'b0;
    if (state != SEARCH) begin
      if (hs_rise && (line_cnt + 12'd1 != 12'(H_TOTAL))) h_err_nx = 1'b1;
      if (hs_fall && (hs_run != 12'(H_SYNC_LEN)))        h_err_nx = 1'b1;
    end
    // Armed only once a vsync rise has been seen in V_ACQ/LOCKED
    if (v_armed) begin
      if (vs_rise && (frame_lines != 11'(V_TOTAL))) v_err_nx = 1'b1;
      if (vs_fall && (vs_run != 11'(V_SYNC_LEN)))   v_err_nx = 1'b1;
    end
  end

  assign wd_trip = (state != SEARCH) && !hs_rise && (line_cnt >= WD_LIMIT);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    armed_nx = v_armed;
    if (wd_trip) begin
      state_nx = SEARCH;
    end else begin
      case (state)
        SEARCH: if (hs_rise) begin
          state_nx = H_ACQ;
          good_nx  = 8'd0;
        end
        H_ACQ: if (h_err_nx) begin
          good_nx = 8'd0;
        end else if (hs_rise) begin
          good_nx = good_cnt + 8'd1;
          if (good_cnt == 8'(LOCK_LINES - 1)) state_nx = V_ACQ;
        end
        V_ACQ: if (h_err_nx) begin
          state_nx = H_ACQ;
          good_nx  = 8'd0;
        end else if (vs_rise) begin
          if (v_armed && !v_err_nx) state_nx = LOCKED;
          armed_nx = 1'b1;
        end else if (v_err_nx) begin
          armed_nx = 1'b0;
        end
        LOCKED: if (h_err_nx) begin
          state_nx = H_ACQ;
          good_nx  = 8'd0;
        end else if (v_err_nx) begin
          state_nx = V_ACQ;
          armed_nx = vs_rise;
        end
        default: state_nx = SEARCH;
      endcase
    end
    if (state_nx == SEARCH || state_nx == H_ACQ) armed_nx = 1'b0;
  end

  // Stage 2: counters, measurements, FSM and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH; good_cnt <= 8'd0; v_armed <= 1'b0;
      hcount <= 11'd0; vcount <= 11'd0;
      line_cnt <= 12'd0; hs_run <= 12'd0; frame_lines <= 11'd0; vs_run <= 11'd0;
      hsync_out <= 1'b0; vsync_out <= 1'b0; hblnk_out <= 1'b0; vblnk_out <= 1'b0;
      locked <= 1'b0; h_err <= 1'b0; v_err <= 1'b0;
    end else begin
      state <= state_nx; good_cnt <= good_nx; v_armed <= armed_nx;
      if (hs_rise)     hcount <= 11'(H_SYNC_FIRST);
      else if (h_wrap) hcount <= 11'd0;
      else             hcount <= hcount + 11'd1;
      if (vs_rise)                 vcount <= 11'(V_SYNC_FIRST);
      else if (h_wrap && !hs_rise) vcount <= (vcount == 11'(V_TOTAL - 1)) ? 11'd0 : vcount + 11'd1;
      if (hs_rise)                  line_cnt <= 12'd0;
      else if (line_cnt != 12'hfff) line_cnt <= line_cnt + 12'd1;
      if (hs_rise)                       hs_run <= 12'd1;
      else if (hs_q && hs_run != 12'hfff) hs_run <= hs_run + 12'd1;
      if (vs_rise)                               frame_lines <= {10'd0, hs_rise};
      else if (hs_rise && frame_lines != 11'h7ff) frame_lines <= frame_lines + 11'd1;
      if (vs_rise)                                 vs_run <= {10'd0, hs_rise};
      else if (hs_rise && vs_q && vs_run != 11'h7ff) vs_run <= vs_run + 11'd1;
      hsync_out <= hs_q; vsync_out <= vs_q; hblnk_out <= hb_q; vblnk_out <= vb_q;
      locked <= (state_nx == LOCKED);
      h_err  <= h_err_nx;
      v_err  <= v_err_nx;
    end
  end

endmodule
